// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the decode stage of the pipelined core.
// Keeps {valid, rd, tnew} for each in-flight writer past decode and, from the
// decode-stage source operands, derives the stall request and per-port
// forwarding selects. A saturating counter records stalled cycles.
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int PORTS  = 2,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int CW     = 32,
  parameter int SW     = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic                  dec_wen,
  input  logic [AW-1:0]         dec_rd,
  input  logic [TW-1:0]         dec_tnew,
  input  logic [PORTS*AW-1:0]   dec_src_addr,
  input  logic [PORTS-1:0]      dec_src_used,
  input  logic [PORTS*TW-1:0]   dec_src_tuse,
  input  logic                  dec_multi,
  input  logic                  md_busy,
  input  logic                  flush,
  output logic                  stall,
  output logic [PORTS*SW-1:0]   fwd_sel,
  output logic [PORTS-1:0]      fwd_ready,
  output logic [SW-1:0]         occupancy,
  output logic [CW-1:0]         stall_cycles
);

  // Tracked entries, index 1 = EX (youngest) ... STAGES = WB (oldest).
  logic [STAGES:1] valid_q, valid_d;
  logic [AW-1:0]   rd_q   [1:STAGES];
  logic [AW-1:0]   rd_d   [1:STAGES];
  logic [TW-1:0]   tnew_q [1:STAGES];
  logic [TW-1:0]   tnew_d [1:STAGES];

  logic [CW-1:0]    stall_cycles_q, stall_cycles_d;
  logic [PORTS-1:0] port_hazard;

  // Per-port compare against every tracked entry.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [AW-1:0] addr;
    logic [TW-1:0] tuse;
    logic [SW-1:0] sel;
    logic          rdy;
    logic          hz;

    assign addr = dec_src_addr[p*AW +: AW];
    assign tuse = dec_src_tuse[p*TW +: TW];

    // Youngest matching producer wins the select; any unready match is a hazard.
    always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      sel = '0;
      rdy = 1'b0;
      hz  = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
        if (valid_q[k] && (rd_q[k] == addr) && (addr != '0)) begin
          sel = SW'(k);
          rdy = (tnew_q[k] == '0);
          if (dec_src_used[p] && (tuse < tnew_q[k])) hz = 1'b1;
        end
      end
    end

    assign fwd_sel[p*SW +: SW] = sel;
    assign fwd_ready[p]        = rdy;
    assign port_hazard[p]      = hz;
  end

  // Stall is forced low while reset is asserted so the decode side sees a
  // quiet scoreboard even if the multiply/divide interlock inputs are active.
  assign stall = reset & dec_valid & ((|port_hazard) | (dec_multi & md_busy));

  // Count of valid tracked entries.
  always_comb begin
    occupancy = '0;
    for (int k = 1; k <= STAGES; k++) begin
      occupancy = occupancy + SW'(valid_q[k]);
    end
  end

  // Next entry state: flush clears, otherwise shift with tnew countdown and
  // load stage 1 from decode (a stall loads a bubble).
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    tnew_d  = tnew_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        tnew_d[k]  = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TW'(1) : '0;
      end
      valid_d[1] = dec_valid & dec_wen & (dec_rd != '0) & ~stall;
      rd_d[1]    = dec_rd;
      tnew_d[1]  = dec_tnew;
    end
  end

  // Saturating stalled-cycle count; flush does not clear it.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CW'(1);
  end

  // Valid bits and the counter are the only state that must come out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q        <= valid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Entry payload follows the shift; its contents only matter behind valid.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; valid_q gates every use of it.
    rd_q   <= rd_d;
    tnew_q <= tnew_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, all compared against an in-flight instruction list model.
module tb_hazard_scoreboard;

  localparam int STAGES = 3;
  localparam int PORTS  = 2;
  localparam int AW     = 5;
  localparam int TW     = 2;
  localparam int CW     = 4;
  localparam int SW     = $clog2(STAGES + 1);
  localparam int CMAX   = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                dec_valid, dec_wen, dec_multi, md_busy, flush;
  logic [AW-1:0]       dec_rd;
  logic [TW-1:0]       dec_tnew;
  logic [PORTS*AW-1:0] dec_src_addr;
  logic [PORTS-1:0]    dec_src_used;
  logic [PORTS*TW-1:0] dec_src_tuse;
  logic                stall;
  logic [PORTS*SW-1:0] fwd_sel;
  logic [PORTS-1:0]    fwd_ready;
  logic [SW-1:0]       occupancy;
  logic [CW-1:0]       stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .STAGES(STAGES), .PORTS(PORTS), .AW(AW), .TW(TW), .CW(CW), .SW(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_wen(dec_wen), .dec_rd(dec_rd), .dec_tnew(dec_tnew),
    .dec_src_addr(dec_src_addr), .dec_src_used(dec_src_used), .dec_src_tuse(dec_src_tuse),
    .dec_multi(dec_multi), .md_busy(md_busy), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .fwd_ready(fwd_ready),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each in-flight writer with its entry tnew and how far it has gone.
  typedef struct { int rd; int tnew0; int stage; } inst_t;
  inst_t pipe[$];   // front = youngest
  int    model_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int remaining(input inst_t i);
    int r = i.tnew0 - (i.stage - 1);
    return (r < 0) ? 0 : r;
  endfunction

  task automatic model_outputs(output bit e_stall, output logic [PORTS*SW-1:0] e_sel,
                               output logic [PORTS-1:0] e_rdy);
    bit hz = 0;
    e_sel = '0;
    e_rdy = '0;
    for (int p = 0; p < PORTS; p++) begin
      int addr = int'(dec_src_addr[p*AW +: AW]);
      int tuse = int'(dec_src_tuse[p*TW +: TW]);
      int best = -1;
      for (int i = 0; i < pipe.size(); i++) begin
        if (addr != 0 && pipe[i].rd == addr) begin
          if (best < 0 || pipe[i].stage < pipe[best].stage) best = i;
          if (dec_src_used[p] && remaining(pipe[i]) > tuse) hz = 1;
        end
      end
      if (best >= 0) begin
        e_sel[p*SW +: SW] = SW'(pipe[best].stage);
        e_rdy[p]          = (remaining(pipe[best]) == 0);
      end
    end
    e_stall = reset && dec_valid && (hz || (dec_multi && md_busy));
  endtask

  // One clock: check combinational outputs, advance model, check counter.
  task automatic step(input string tag);
    bit                  e_stall;
    logic [PORTS*SW-1:0] e_sel;
    logic [PORTS-1:0]    e_rdy;
    #1;
    model_outputs(e_stall, e_sel, e_rdy);
    check({tag, "_stall"}, stall, e_stall);
    check({tag, "_fwd_sel"}, fwd_sel, e_sel);
    check({tag, "_fwd_ready"}, fwd_ready, e_rdy);
    check({tag, "_occupancy"}, occupancy, pipe.size());
    @(posedge clk);
    if (flush) begin
      pipe.delete();
    end else begin
      foreach (pipe[i]) pipe[i].stage++;
      while (pipe.size() > 0 && pipe[$].stage > STAGES) void'(pipe.pop_back());
      if (dec_valid && dec_wen && dec_rd != 0 && !e_stall)
        pipe.push_front('{int'(dec_rd), int'(dec_tnew), 1});
    end
    if (e_stall && model_cnt != CMAX) model_cnt++;
    @(negedge clk);
    #1;
    check({tag, "_stall_cycles"}, stall_cycles, model_cnt);
  endtask

  task automatic drive(input bit v, input bit w, input int rd, input int tn,
                       input int a0, input bit u0, input int t0,
                       input int a1, input bit u1, input int t1,
                       input bit m, input bit b, input bit f);
    dec_valid    = v;
    dec_wen      = w;
    dec_rd       = AW'(rd);
    dec_tnew     = TW'(tn);
    dec_src_addr = {AW'(a1), AW'(a0)};
    dec_src_used = {u1, u0};
    dec_src_tuse = {TW'(t1), TW'(t0)};
    dec_multi    = m;
    md_busy      = b;
    flush        = f;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_rst_stall"}, stall, 0);
    check({tag, "_rst_fwd_sel"}, fwd_sel, 0);
    check({tag, "_rst_fwd_ready"}, fwd_ready, 0);
    check({tag, "_rst_occupancy"}, occupancy, 0);
    check({tag, "_rst_stall_cycles"}, stall_cycles, 0);
    pipe.delete();
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset("init");

    // 1: load-use with tuse=1 -> one stall, then forward from stage 2, then 3.
    drive(1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t1_lw");
    drive(1, 1, 4, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    #1 check("t1_stall_hi", stall, 1);
    step("t1_c1");
    check("t1_cnt1", stall_cycles, 1);
    check("t1_stall_lo", stall, 0);
    check("t1_sel2", fwd_sel[SW-1:0], 2);
    check("t1_notready", fwd_ready[0], 0);
    step("t1_c2");
    drive(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t1_sel3", fwd_sel[SW-1:0], 3);
    check("t1_ready", fwd_ready[0], 1);
    step("t1_c3");

    // 2: branch with tuse=0 on a load -> two stalls, then stage 3 ready.
    do_reset("t2");
    drive(1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t2_lw");
    drive(1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_c1");
    step("t2_c2");
    check("t2_cnt2", stall_cycles, 2);
    check("t2_stall_lo", stall, 0);
    check("t2_sel3", fwd_sel[SW-1:0], 3);
    check("t2_ready", fwd_ready[0], 1);
    step("t2_c3");

    // 3: ALU producer, tuse=0 consumer; then two writers of $3 in flight.
    do_reset("t3");
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t3_addu");
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    #1 check("t3_stall_hi", stall, 1);
    step("t3_c1");
    check("t3_sel2", fwd_sel[2*SW-1:SW], 2);
    check("t3_ready", fwd_ready[1], 1);
    step("t3_c2");
    do_reset("t3b");
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t3_w1");
    step("t3_w2");
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t3_young", fwd_sel[SW-1:0], 1);
    step("t3_c3");

    // 4: $0 writers/readers and non-writers never track or stall.
    do_reset("t4");
    drive(1, 1, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    step("t4_w0");
    drive(1, 0, 5, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    step("t4_nw");
    check("t4_occ", occupancy, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    step("t4_rd0");

    // 5: multi-cycle unit busy for exactly 4 cycles.
    do_reset("t5");
    drive(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step("t5_busy");
    check("t5_cnt4", stall_cycles, 4);
    check("t5_bubbles", occupancy, 0);
    drive(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("t5_go");

    // 6: flush during a stall, then async reset mid-cycle.
    do_reset("t6");
    drive(1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t6_lw");
    drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("t6_st");
    drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("t6_flush");
    drive(0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t6_occ0", occupancy, 0);
    check("t6_stall0", stall, 0);
    step("t6_after");
    drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("t6_st2");
    #2;
    do_reset("t6_async");

    // Random traffic with small register range to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 5) == 0, $urandom_range(0, 1),
            $urandom_range(0, 19) == 0);
      step("rnd");
    end
    check("rnd_saturated", stall_cycles, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
